// File: rtl/motoro_sixstep_gen.sv
// motoro_sixstep_gen: six-step BLDC commutation with soft-start ramp, dead time and reverse/stop control
module motoro_sixstep_gen #(
    parameter int PER_W        = 10,
    parameter int PRESCALE     = 500,
    parameter int START_PERIOD = 1000,
    parameter int MIN_PERIOD   = 4,
    parameter int RAMP_DEC     = 1,
    parameter int DEAD_CYCLES  = 25,
    parameter int INV_MODE     = 1
) (
    input  logic             clk50mhz,
    input  logic             reset,
    input  logic             m3start,
    input  logic             m3invOrStop,
    input  logic [PER_W-1:0] m3period,
    output logic             aH,
    output logic             aL,
    output logic             bH,
    output logic             bL,
    output logic             cH,
    output logic             cL,
    output logic [2:0]       stepIdx,
    output logic             stepPulse,
    output logic             running,
    output logic             ramping
);
    localparam int PS_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int DC_W = DEAD_CYCLES > 0 ? $clog2(DEAD_CYCLES + 1) : 1;
    // {aH,aL,bH,bL,cH,cL} per step; entries 6 and 7 are unreachable
    localparam logic [5:0] PAT [8] = '{6'b100100, 6'b100001, 6'b001001, 6'b011000,
                                       6'b010010, 6'b000110, 6'b000000, 6'b000000};
    typedef enum logic [1:0] {IDLE, RAMP, RUN} state_t;
    state_t state_q, state_d;
    logic [PS_W-1:0]  pre_q, pre_d;
    logic [PER_W-1:0] tick_q, tick_d, cur_q, cur_d, target, cur_next;
    logic [2:0]       step_q, step_d;
    logic [DC_W-1:0]  dead_q, dead_d;
    logic [5:0]       gates_q, gates_d;
    logic             pulse_q, pulse_d;
    logic             run_ok, tick_en, bound, go, start;
    always_ff @(posedge clk50mhz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pre_q   <= '0;
            tick_q  <= '0;
            cur_q   <= PER_W'(START_PERIOD);
            step_q  <= '0;
            dead_q  <= '0;
            gates_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            cur_q   <= cur_d;
            step_q  <= step_d;
            dead_q  <= dead_d;
            gates_q <= gates_d;
            pulse_q <= pulse_d;
        end
    end
    always_comb begin
        run_ok   = m3start && (m3period != '0) && !(INV_MODE == 0 && m3invOrStop);
        target   = m3period < PER_W'(MIN_PERIOD) ? PER_W'(MIN_PERIOD) : m3period;
        tick_en  = pre_q == PS_W'(PRESCALE - 1);
        bound    = state_q != IDLE && tick_en && tick_q == cur_q - PER_W'(1);
        // widened compare so target + RAMP_DEC cannot wrap
        cur_next = ({1'b0, cur_q} > {1'b0, target} + (PER_W + 1)'(RAMP_DEC)) ? cur_q - PER_W'(RAMP_DEC) : target;
        state_d  = !run_ok ? IDLE : state_q == IDLE ? RAMP : bound ? (cur_next == target ? RUN : RAMP) : state_q;
    end
    always_comb begin
        go      = state_d != IDLE;
        start   = state_q == IDLE && go;
        pre_d   = (!go || start || tick_en) ? '0 : pre_q + PS_W'(1);
        tick_d  = (!go || start || bound) ? '0 : tick_en ? tick_q + PER_W'(1) : tick_q;
        cur_d   = !go ? PER_W'(START_PERIOD) : bound ? cur_next : cur_q;
        step_d  = start ? 3'd0 : !(bound && go) ? step_q :
                  (INV_MODE != 0 && m3invOrStop) ? (step_q == 3'd0 ? 3'd5 : step_q - 3'd1) :
                  (step_q == 3'd5 ? 3'd0 : step_q + 3'd1);
        pulse_d = bound && go;
        dead_d  = (!go || start || bound) ? '0 : dead_q == DC_W'(DEAD_CYCLES) ? dead_q : dead_q + DC_W'(1);
        gates_d = (go && !start && !bound && dead_d == DC_W'(DEAD_CYCLES)) ? PAT[step_q] : 6'b0;
    end
    always_comb begin
        {aH, aL, bH, bL, cH, cL} = gates_q;
        stepIdx   = step_q;
        stepPulse = pulse_q;
        running   = state_q != IDLE;
        ramping   = state_q == RAMP;
    end
endmodule

// File: tb/tb_motoro_sixstep_gen.sv
// tb_motoro_sixstep_gen: directed checks of ramp, dead time, reverse, retarget, stop and reset paths
module tb_motoro_sixstep_gen;
    logic clk = 1'b0, reset = 1'b1;
    logic m3start = 1'b0, m3invOrStop = 1'b0, start1 = 1'b0, inv1 = 1'b0;
    logic [9:0] m3period = '0, period1 = '0;
    logic aH, aL, bH, bL, cH, cL, stepPulse, running, ramping;
    logic aH1, aL1, bH1, bL1, cH1, cL1, stepPulse1, running1, ramping1;
    logic [2:0] stepIdx, stepIdx1;
    logic [5:0] pat [6] = '{6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110};
    logic [2:0] idx = 3'd0;
    int tests = 0, fails = 0;
    wire [5:0] gates0 = {aH, aL, bH, bL, cH, cL};
    wire [5:0] gates1 = {aH1, aL1, bH1, bL1, cH1, cL1};
    always #5 clk = ~clk;
    motoro_sixstep_gen #(.PER_W(10), .PRESCALE(4), .START_PERIOD(20), .MIN_PERIOD(4),
        .RAMP_DEC(2), .DEAD_CYCLES(3), .INV_MODE(1)) u0 (
        .clk50mhz(clk), .reset(reset), .m3start(m3start), .m3invOrStop(m3invOrStop),
        .m3period(m3period), .aH(aH), .aL(aL), .bH(bH), .bL(bL), .cH(cH), .cL(cL),
        .stepIdx(stepIdx), .stepPulse(stepPulse), .running(running), .ramping(ramping));
    motoro_sixstep_gen #(.PER_W(10), .PRESCALE(4), .START_PERIOD(20), .MIN_PERIOD(4),
        .RAMP_DEC(2), .DEAD_CYCLES(3), .INV_MODE(0)) u1 (
        .clk50mhz(clk), .reset(reset), .m3start(start1), .m3invOrStop(inv1),
        .m3period(period1), .aH(aH1), .aL(aL1), .bH(bH1), .bL(bL1), .cH(cH1), .cL(cL1),
        .stepIdx(stepIdx1), .stepPulse(stepPulse1), .running(running1), .ramping(ramping1));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    always @(negedge clk) begin
        chk("overlap0", {29'd0, aH & aL, bH & bL, cH & cL}, 32'd0);
        chk("overlap1", {29'd0, aH1 & aL1, bH1 & bL1, cH1 & cL1}, 32'd0);
    end
    // called at the negedge just after a step-start edge; returns at the negedge after the next stepPulse
    task automatic step_check(input int len, input bit rev, input bit exp_ramp);
        int n;
        logic [2:0] nx;
        nx = rev ? (idx == 3'd0 ? 3'd5 : idx - 3'd1) : (idx == 3'd5 ? 3'd0 : idx + 3'd1);
        n = 0;
        chk("dead_first", gates0, 6'b0);
        while (n < len + 8) begin
            @(negedge clk);
            n++;
            if (stepPulse) break;
            if (n < 3) chk("dead", gates0, 6'b0);
            if (n == 3) chk("pattern", gates0, pat[idx]);
        end
        chk("step_len", n, len);
        chk("pulse_gates_off", gates0, 6'b0);
        chk("step_idx", stepIdx, nx);
        chk("ramping", ramping, exp_ramp);
        idx = nx;
    endtask
    initial begin
        #1;
        chk("rst_gates", gates0, 6'b0);
        chk("rst_idx", stepIdx, 3'd0);
        chk("rst_pulse", stepPulse, 1'b0);
        chk("rst_running", running, 1'b0);
        chk("rst_ramping", ramping, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_running", running, 1'b0);
        m3period = 10'd10;
        m3start = 1'b1;
        @(negedge clk);
        chk("start_running", running, 1'b1);
        chk("start_ramping", ramping, 1'b1);
        chk("start_idx", stepIdx, 3'd0);
        idx = 3'd0;
        step_check(80, 0, 1);
        step_check(72, 0, 1);
        step_check(64, 0, 1);
        step_check(56, 0, 1);
        step_check(48, 0, 0);
        step_check(40, 0, 0);
        step_check(40, 0, 0);
        step_check(40, 0, 0);
        chk("rev_at2", idx, 3'd2);
        m3invOrStop = 1'b1;
        step_check(40, 1, 0);
        step_check(40, 1, 0);
        step_check(40, 1, 0);
        step_check(40, 1, 0);
        m3invOrStop = 1'b0;
        step_check(40, 0, 0);
        m3period = 10'd30;
        step_check(40, 0, 0);
        step_check(120, 0, 0);
        m3period = 10'd2;
        step_check(120, 0, 1);
        for (int p = 28; p > 4; p -= 2) step_check(p * 4, 0, (p - 2) != 4);
        step_check(16, 0, 0);
        repeat (5) @(negedge clk);
        chk("stop_before", gates0, pat[idx]);
        m3start = 1'b0;
        @(negedge clk);
        chk("stop_gates", gates0, 6'b0);
        chk("stop_running", running, 1'b0);
        chk("stop_ramping", ramping, 1'b0);
        m3start = 1'b1;
        @(negedge clk);
        chk("restart_running", running, 1'b1);
        chk("restart_idx", stepIdx, 3'd0);
        idx = 3'd0;
        step_check(80, 0, 1);
        repeat (5) @(negedge clk);
        chk("pstop_before", gates0, pat[idx]);
        m3period = 10'd0;
        @(negedge clk);
        chk("pstop_gates", gates0, 6'b0);
        chk("pstop_running", running, 1'b0);
        m3period = 10'd10;
        @(negedge clk);
        chk("prestart_idx", stepIdx, 3'd0);
        idx = 3'd0;
        step_check(80, 0, 1);
        repeat (5) @(negedge clk);
        chk("rpulse_before", gates0, pat[idx]);
        m3start = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_gates", gates0, 6'b0);
        chk("async_idx", stepIdx, 3'd0);
        chk("async_running", running, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        period1 = 10'd10;
        inv1 = 1'b1;
        @(negedge clk);
        chk("inv0_blocked", running1, 1'b0);
        inv1 = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        chk("inv0_running", running1, 1'b1);
        repeat (4) @(negedge clk);
        chk("inv0_pattern", gates1, pat[0]);
        inv1 = 1'b1;
        @(negedge clk);
        chk("inv0_stop_gates", gates1, 6'b0);
        chk("inv0_stop_running", running1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
